// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: instruction/data memory request-ready handshake bundle
//   imem_req/dmem_req   controller -> memory, request held until the matching ready
//   imem_ready/dmem_ready memory -> controller, acknowledges the request in that cycle
interface multicycle_control_unit_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_ready;
    modport master (output imem_req, dmem_req, input imem_ready, dmem_ready);
    modport slave (input imem_req, dmem_req, output imem_ready, dmem_ready);
endinterface

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multi-cycle RV32I control FSM (FETCH/DECODE/EXECUTE/MEM/WB/TRAP)
//   clk, rst            clock and synchronous active-high reset
//   opcode              instr[6:0] from IR, captured in DECODE
//   mem                 imem/dmem req-ready handshakes (master side)
//   IRWrite..Jump       datapath enables and mux selects
//   trap, trap_cause    sticky trap flag and cause (0 illegal, 1 system, 2 memory timeout)
//   instret             retired-instruction count, one per PCWrite pulse
module multicycle_control_unit #(
    parameter bit ENABLE_SYSTEM = 1'b1,
    parameter int MEM_TIMEOUT   = 0,
    parameter int TO_W          = 8,
    parameter int CNT_W         = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    multicycle_control_unit_if.master mem,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 Branch,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 MemtoReg,
    output logic                 ALUSrc,
    output logic [1:0]           ALUOp,
    output logic                 RegWrite,
    output logic                 Jump,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [CNT_W-1:0]     instret
);
    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, TRAP} state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    state_t           state;
    logic [6:0]       op_q;
    logic [TO_W-1:0]  cnt;
    logic [1:0]       cause_q;
    logic [CNT_W-1:0] ret_q;

    // {ALUSrc, ALUOp, MemtoReg, Jump}
    function automatic logic [4:0] decode(input logic [6:0] op);
        case (op)
            OP_R:     decode = 5'b0_10_0_0;
            OP_I:     decode = 5'b1_10_0_0;
            OP_LD:    decode = 5'b1_00_1_0;
            OP_ST:    decode = 5'b1_00_0_0;
            OP_BR:    decode = 5'b0_01_0_0;
            OP_JAL:   decode = 5'b0_10_0_1;
            OP_JALR:  decode = 5'b1_00_0_1;
            OP_LUI:   decode = 5'b1_11_0_0;
            OP_AUIPC: decode = 5'b1_00_0_0;
            default:  decode = 5'b0_00_0_0;
        endcase
    endfunction

    function automatic logic legal(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    endfunction

    logic run, in_fetch, in_mem, is_ld, is_st, is_br, waiting, expire;

    // Every output is forced low while rst is high, so an aborted instruction
    // never issues PCWrite/RegWrite or keeps a memory request alive.
    assign run      = !rst;
    assign in_fetch = run && state == FETCH;
    assign in_mem   = run && state == MEM;
    assign is_ld    = op_q == OP_LD;
    assign is_st    = op_q == OP_ST;
    assign is_br    = op_q == OP_BR;

    assign mem.imem_req = in_fetch;
    assign mem.dmem_req = in_mem;
    assign IRWrite      = in_fetch && mem.imem_ready;
    assign Branch       = run && state == EXECUTE && is_br;
    assign MemRead      = in_mem && is_ld;
    assign MemWrite     = in_mem && is_st;
    assign RegWrite     = run && state == WB;
    assign PCWrite      = Branch || RegWrite || (MemWrite && mem.dmem_ready);
    assign trap         = run && state == TRAP;
    assign trap_cause   = run ? cause_q : 2'd0;
    assign instret      = run ? ret_q : '0;
    assign {ALUSrc, ALUOp, MemtoReg, Jump} =
        (run && state inside {EXECUTE, MEM, WB}) ? decode(op_q) : 5'b0;

    // A waiting cycle is the only way to stay in FETCH/MEM, so clearing cnt on
    // every non-waiting cycle is the same as clearing it on state entry.
    assign waiting = (in_fetch && !mem.imem_ready) || (in_mem && !mem.dmem_ready);
    assign expire  = MEM_TIMEOUT != 0 && waiting && cnt == TO_W'(MEM_TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            op_q    <= '0;
            cnt     <= '0;
            cause_q <= 2'd0;
            ret_q   <= '0;
        end else begin
            cnt <= waiting ? cnt + 1'b1 : '0;
            if (PCWrite) ret_q <= ret_q + 1'b1;
            if (expire) begin
                state   <= TRAP;
                cause_q <= 2'd2;
            end else begin
                case (state)
                    FETCH:   if (mem.imem_ready) state <= DECODE;
                    DECODE: begin
                        op_q    <= opcode;
                        state   <= legal(opcode) ? EXECUTE : TRAP;
                        cause_q <= (ENABLE_SYSTEM && opcode == OP_SYS) ? 2'd1 : 2'd0;
                    end
                    EXECUTE: state <= (is_ld || is_st) ? MEM : is_br ? FETCH : WB;
                    MEM:     if (mem.dmem_ready) state <= is_ld ? WB : FETCH;
                    WB:      state <= FETCH;
                    default: state <= TRAP;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: table, directed and randomized checks of the control FSM
module tb_multicycle_control_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [6:0] opcode = '0;
    logic imem_ready = 1'b0, dmem_ready = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_unit_if ia();
    multicycle_control_unit_if ib();
    assign ia.imem_ready = imem_ready;
    assign ia.dmem_ready = dmem_ready;
    assign ib.imem_ready = imem_ready;
    assign ib.dmem_ready = dmem_ready;

    logic irw_a, pcw_a, br_a, mr_a, mw_a, m2r_a, as_a, rw_a, j_a, tr_a;
    logic [1:0] aop_a, tc_a;
    logic [3:0] ret_a;
    logic irw_b, pcw_b, br_b, mr_b, mw_b, m2r_b, as_b, rw_b, j_b, tr_b;
    logic [1:0] aop_b, tc_b;
    logic [31:0] ret_b;

    multicycle_control_unit #(.ENABLE_SYSTEM(1'b1), .MEM_TIMEOUT(4), .TO_W(8), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .opcode(opcode), .mem(ia),
        .IRWrite(irw_a), .PCWrite(pcw_a), .Branch(br_a), .MemRead(mr_a), .MemWrite(mw_a),
        .MemtoReg(m2r_a), .ALUSrc(as_a), .ALUOp(aop_a), .RegWrite(rw_a), .Jump(j_a),
        .trap(tr_a), .trap_cause(tc_a), .instret(ret_a)
    );

    multicycle_control_unit #(.ENABLE_SYSTEM(1'b0), .MEM_TIMEOUT(0), .TO_W(8), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst), .opcode(opcode), .mem(ib),
        .IRWrite(irw_b), .PCWrite(pcw_b), .Branch(br_b), .MemRead(mr_b), .MemWrite(mw_b),
        .MemtoReg(m2r_b), .ALUSrc(as_b), .ALUOp(aop_b), .RegWrite(rw_b), .Jump(j_b),
        .trap(tr_b), .trap_cause(tc_b), .instret(ret_b)
    );

    // [15]imem_req [14]dmem_req [13]IRWrite [12]PCWrite [11]Branch [10]MemRead [9]MemWrite
    // [8]RegWrite [7]MemtoReg [6]ALUSrc [5:4]ALUOp [3]Jump [2]trap [1:0]trap_cause
    logic [15:0] act_a, act_b, act;
    logic [31:0] ret_act;
    logic sel = 1'b0;
    assign act_a = {ia.imem_req, ia.dmem_req, irw_a, pcw_a, br_a, mr_a, mw_a, rw_a,
                    m2r_a, as_a, aop_a, j_a, tr_a, tc_a};
    assign act_b = {ib.imem_req, ib.dmem_req, irw_b, pcw_b, br_b, mr_b, mw_b, rw_b,
                    m2r_b, as_b, aop_b, j_b, tr_b, tc_b};
    assign act = sel ? act_b : act_a;
    assign ret_act = sel ? ret_b : {28'b0, ret_a};

    localparam logic [6:0] R = 7'b0110011, LD = 7'b0000011, ST = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011, SYS = 7'b1110011;

    typedef struct {
        logic [6:0] op;
        logic [4:0] ctl;    // {MemtoReg, ALUSrc, ALUOp, Jump}
        int         lat;    // cycles to retire with zero-wait memory, 0 = traps
        logic [1:0] cause;  // expected cause on the ENABLE_SYSTEM=1 unit
    } vec_t;
    vec_t tab[12];

    int checks = 0, errors = 0;
    int unsigned exp_ret = 0, ret_mask = 32'hf;
    int cfg_to = 4;
    bit cfg_es = 1'b1, trapped = 1'b0;
    logic [1:0] cause = 2'd0;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [15:0] v(input logic [7:0] s, input logic [4:0] c);
        return {s, c, 3'b000};
    endfunction

    function automatic int find(input logic [6:0] op);
        for (int i = 0; i < 12; i++)
            if (tab[i].op == op && tab[i].lat != 0) return i;
        return -1;
    endfunction

    task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic set_dut(input bit s);
        sel = s;
        cfg_to = s ? 0 : 4;
        cfg_es = !s;
        ret_mask = s ? 32'hffff_ffff : 32'hf;
    endtask

    task automatic cyc(input string nm, input logic ir, input logic dr, input logic [15:0] e);
        imem_ready = ir;
        dmem_ready = dr;
        @(negedge clk);
        check(nm, 32'(act), 32'(e));
        check({nm, " instret"}, ret_act, exp_ret & ret_mask);
        @(posedge clk);
        #1;
        if (e[12]) exp_ret++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_ret = 0;
        repeat (2) cyc("reset", rb(), rb(), 16'h0);
        rst = 1'b0;
        trapped = 1'b0;
        cause = 2'd0;
    endtask

    task automatic trap_hold(input int n);
        repeat (n) begin
            opcode = 7'($urandom);
            cyc("trap", rb(), rb(), {13'b0, 1'b1, cause});
        end
    endtask

    // Expected per-cycle behaviour of one instruction, built from its phases:
    // fw fetch wait cycles, decode, execute, mw data wait cycles, writeback.
    task automatic do_instr(input logic [6:0] op, input int fw, input int mw);
        int k;
        logic [4:0] c;
        logic ld, st;
        k = find(op);
        c = (k >= 0) ? tab[k].ctl : 5'b0;
        ld = op == LD;
        st = op == ST;
        opcode = op;
        for (int i = 0; i <= fw; i++) begin
            if (cfg_to != 0 && i == cfg_to) begin
                trapped = 1'b1;
                cause = 2'd2;
                return;
            end
            cyc("fetch", i == fw, rb(), v({2'b10, i == fw, 5'b0}, 5'b0));
        end
        cyc("decode", rb(), rb(), 16'h0);
        opcode = 7'($urandom);
        if (k < 0) begin
            trapped = 1'b1;
            cause = (op == SYS && cfg_es) ? 2'd1 : 2'd0;
            return;
        end
        if (op == BR) begin
            cyc("exec br", rb(), rb(), v(8'b0001_1000, c));
            return;
        end
        cyc("exec", rb(), rb(), v(8'h00, c));
        if (ld || st) begin
            for (int i = 0; i <= mw; i++) begin
                if (cfg_to != 0 && i == cfg_to) begin
                    trapped = 1'b1;
                    cause = 2'd2;
                    return;
                end
                cyc("mem", rb(), i == mw, v({3'b010, st && i == mw, 1'b0, ld, st, 1'b0}, c));
            end
            if (st) return;
        end
        cyc("wb", rb(), rb(), v(8'b0001_0001, c));
    endtask

    initial begin
        tab[0]  = '{7'b0110011, 5'b00100, 4, 2'd0};
        tab[1]  = '{7'b0010011, 5'b01100, 4, 2'd0};
        tab[2]  = '{7'b0000011, 5'b11000, 5, 2'd0};
        tab[3]  = '{7'b0100011, 5'b01000, 4, 2'd0};
        tab[4]  = '{7'b1100011, 5'b00010, 3, 2'd0};
        tab[5]  = '{7'b1101111, 5'b00101, 4, 2'd0};
        tab[6]  = '{7'b1100111, 5'b01001, 4, 2'd0};
        tab[7]  = '{7'b0110111, 5'b01110, 4, 2'd0};
        tab[8]  = '{7'b0010111, 5'b01000, 4, 2'd0};
        tab[9]  = '{7'b1110011, 5'b00000, 0, 2'd1};
        tab[10] = '{7'b0000000, 5'b00000, 0, 2'd0};
        tab[11] = '{7'b1111111, 5'b00000, 0, 2'd0};

        set_dut(1'b0);
        for (int i = 0; i < 12; i++) begin
            int lat;
            logic [4:0] ctl;
            do_reset();
            imem_ready = 1'b1;
            dmem_ready = 1'b1;
            opcode = tab[i].op;
            lat = 0;
            ctl = '0;
            for (int c = 0; c < 8 && lat == 0; c++) begin
                @(negedge clk);
                if (c == 2) ctl = act[7:3];
                if (act[12]) lat = c + 1;
                @(posedge clk);
                #1;
            end
            check($sformatf("tbl %b latency", tab[i].op), lat, tab[i].lat);
            if (tab[i].lat != 0) check($sformatf("tbl %b ctl", tab[i].op), 32'(ctl), 32'(tab[i].ctl));
            else check($sformatf("tbl %b trap", tab[i].op), 32'(act[2:0]), {29'b0, 1'b1, tab[i].cause});
        end

        do_reset();
        do_instr(R, 0, 0);
        do_instr(LD, 0, 3);
        check("ld delayed instret", ret_act, 32'd2);
        do_instr(7'b0000000, 1, 0);
        trap_hold(4);
        do_reset();
        do_instr(ST, 0, 3);
        do_instr(ST, 0, 4);
        check("st timeout", 32'(trapped), 32'd1);
        trap_hold(3);
        do_reset();
        do_instr(R, 4, 0);
        trap_hold(2);
        do_reset();
        do_instr(SYS, 0, 0);
        trap_hold(2);
        do_reset();
        repeat (16) do_instr(BR, 0, 0);
        check("instret wrap", ret_act, 32'd0);
        do_instr(BR, 2, 0);

        do_reset();
        opcode = ST;
        cyc("rst-mem fetch", 1'b1, 1'b0, v(8'b1010_0000, 5'b0));
        cyc("rst-mem decode", 1'b0, 1'b0, 16'h0);
        cyc("rst-mem exec", 1'b0, 1'b0, v(8'h00, 5'b01000));
        cyc("rst-mem mem", 1'b0, 1'b0, v(8'b0100_0010, 5'b01000));
        rst = 1'b1;
        cyc("rst-mem abort", 1'b1, 1'b1, 16'h0);
        rst = 1'b0;
        exp_ret = 0;
        cyc("rst-mem after", 1'b0, 1'b1, v(8'b1000_0000, 5'b0));

        set_dut(1'b1);
        do_reset();
        do_instr(SYS, 0, 0);
        trap_hold(2);

        for (int s = 0; s < 2; s++) begin
            set_dut(1'(s));
            do_reset();
            for (int n = 0; n < 80; n++) begin
                int r, fw, mw;
                logic [6:0] op;
                r = $urandom_range(0, 19);
                op = (r < 16) ? tab[r % 9].op : (r < 18) ? SYS : 7'($urandom);
                fw = ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(0, 2);
                mw = ($urandom_range(0, 5) == 0) ? $urandom_range(3, 5) : $urandom_range(0, 2);
                do_instr(op, fw, mw);
                if (trapped) begin
                    trap_hold(2);
                    do_reset();
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
